// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller. The definitions are:
//     - state_e   : wait-FSM state encoding (ST_RUN / ST_WAIT)
//     - hazard_e  : hazard-priority codes. The tracer uses the same codes to
//                   decode which rule fired in a cycle.
//     - ctrl_t    : bundle of stall/bubble pins
//     - helpers   : load-use detection and rule -> control mapping
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;  // architectural register index width

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // The numeric order matches the resolution priority.
  // HZ_MEM_HOLD is the strongest rule.
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_MEM_HOLD = 3'd1,
    HZ_REDIRECT = 3'd2,
    HZ_LOAD_USE = 3'd3,
    HZ_JAL      = 3'd4
  } hazard_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic bubble_id;
    logic bubble_ex;
    logic bubble_mem;
    logic bubble_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = ctrl_t'(8'b0000_0000);
  // Applied while reset is asserted: nothing held, every pipe register
  // loads a NOP.
  localparam ctrl_t CTRL_FLUSH = ctrl_t'(8'b0000_1111);

  // A register-0 destination never creates a dependency.
  function automatic logic f_load_use(
    input logic             mem_read_ex,
    input logic [REG_W-1:0] rd_ex,
    input logic             rs1_used_id,
    input logic [REG_W-1:0] rs1_id,
    input logic             rs2_used_id,
    input logic [REG_W-1:0] rs2_id
  );
    return mem_read_ex && (rd_ex != '0) &&
           ((rs1_used_id && (rs1_id == rd_ex)) ||
            (rs2_used_id && (rs2_id == rd_ex)));
  endfunction

  function automatic ctrl_t f_rule_ctrl(input hazard_e rule);
    ctrl_t c;
    c = CTRL_IDLE;
    case (rule)
      HZ_MEM_HOLD: begin
        // Freeze everything up to MEM. Drain a NOP into WB so the stuck
        // MEM instruction does not retire twice.
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_ex  = 1'b1;
        c.stall_mem = 1'b1;
        c.bubble_wb = 1'b1;
      end
      HZ_REDIRECT: begin
        c.bubble_id = 1'b1;
        c.bubble_ex = 1'b1;
      end
      HZ_LOAD_USE: begin
        // Hold the consumer in ID and let the load advance into MEM.
        // Forwarding covers the rest of the dependency.
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.bubble_ex = 1'b1;
      end
      HZ_JAL: begin
        c.bubble_id = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Groups every hazard-related signal between the pipeline datapath and the
//   hazard controller.
//     master : pipeline side. Drives the decode/EX/MEM status signals and
//              receives the stall/bubble pins, flags and counters.
//     slave  : hazard controller side.
//   Parameter CNT_W sets the width of the performance counters.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_hazard_ctrl_pkg::*;

  // Pipeline status (into the controller)
  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic             jal_id;
  logic [REG_W-1:0] rd_ex;
  logic             mem_read_ex;
  logic             redirect_ex;
  logic             dmem_req_mem;
  logic             dmem_ack;

  // Controls and status (out of the controller)
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             bubble_id;
  logic             bubble_ex;
  logic             bubble_mem;
  logic             bubble_wb;
  logic             mem_wait;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, jal_id,
           rd_ex, mem_read_ex, redirect_ex, dmem_req_mem, dmem_ack,
    input  stall_if, stall_id, stall_ex, stall_mem,
           bubble_id, bubble_ex, bubble_mem, bubble_wb,
           mem_wait, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, jal_id,
           rd_ex, mem_read_ex, redirect_ex, dmem_req_mem, dmem_ack,
    output stall_if, stall_id, stall_ex, stall_mem,
           bubble_id, bubble_ex, bubble_mem, bubble_wb,
           mem_wait, mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//     i_inc      : add one this cycle (ignored once saturated)
//     i_clear    : synchronous clear. It has priority over i_inc.
//     o_count    : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: state is written with non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/bubble controller for the five-stage pipeline. It resolves
//   the following hazards, from highest to lowest priority:
//     - dmem wait (req without ack)
//     - EX redirect
//     - load-use
//     - ID jal
//   Exactly one rule drives the stall/bubble pins in each cycle. The block
//   also keeps a sticky dmem-wait watchdog and saturating stall/flush
//   counters.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     hz         : pipe_hazard_ctrl_if.slave. Carries the ID/EX/MEM status
//                  in; stall_*/bubble_*, mem_wait, mem_timeout, stall_cnt
//                  and flush_cnt out.
//   mem_wait reflects the registered FSM state. It rises in the cycle after
//   the first un-acked request and stays high through the ack cycle.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  // The wait counter only needs to reach TIMEOUT_CYC. Saturation keeps a
  // long wait from wrapping back below the threshold.
  localparam int unsigned       WAIT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_e            r_state;
  state_e            w_next_state;
  hazard_e           w_rule;
  ctrl_t             w_ctrl;
  logic              w_mem_hold;
  logic              w_load_use;
  logic              w_flush_evt;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic              r_mem_timeout;

  assign w_mem_hold = hz.dmem_req_mem & ~hz.dmem_ack;
  assign w_load_use = f_load_use(hz.mem_read_ex, hz.rd_ex,
                                 hz.rs1_used_id, hz.rs1_id,
                                 hz.rs2_used_id, hz.rs2_id);

  // --- FSM state register --------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // --- next state, rule selection and control outputs ----------------------
  // NOTE: every signal gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_rule       = HZ_NONE;

    case (r_state)
      ST_RUN:  if (w_mem_hold)  w_next_state = ST_WAIT;
      ST_WAIT: if (hz.dmem_ack) w_next_state = ST_RUN;
      default: w_next_state = ST_RUN;
    endcase

    // A held EX/ID keeps its contents. Any masked redirect, load-use or jal
    // therefore re-evaluates once the hold releases.
    if (w_mem_hold)          w_rule = HZ_MEM_HOLD;
    else if (hz.redirect_ex) w_rule = HZ_REDIRECT;
    else if (w_load_use)     w_rule = HZ_LOAD_USE;
    else if (hz.jal_id)      w_rule = HZ_JAL;

    // While reset is asserted, the outputs are a full flush pattern rather
    // than rule-driven. This fills every pipe register with NOPs.
    w_ctrl = rst_n ? f_rule_ctrl(w_rule) : CTRL_FLUSH;
  end

  assign w_flush_evt = (w_rule == HZ_REDIRECT) || (w_rule == HZ_JAL);

  // --- watchdog ------------------------------------------------------------
  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_mem_hold),
    .i_clear (~w_mem_hold),
    .o_count (w_wait_cnt)
  );

  // The flag sets on the edge where the count reaches TIMEOUT_CYC. It is
  // therefore visible right after the TIMEOUT_CYC-th held cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_timeout <= 1'b0;
    end else if (w_mem_hold && (w_wait_cnt >= TO_LAST)) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // --- performance counters ------------------------------------------------
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_ctrl.stall_if),
    .i_clear (1'b0),
    .o_count (hz.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_flush_evt),
    .i_clear (1'b0),
    .o_count (hz.flush_cnt)
  );

  // --- outputs -------------------------------------------------------------
  assign hz.stall_if    = w_ctrl.stall_if;
  assign hz.stall_id    = w_ctrl.stall_id;
  assign hz.stall_ex    = w_ctrl.stall_ex;
  assign hz.stall_mem   = w_ctrl.stall_mem;
  assign hz.bubble_id   = w_ctrl.bubble_id;
  assign hz.bubble_ex   = w_ctrl.bubble_ex;
  assign hz.bubble_mem  = w_ctrl.bubble_mem;
  assign hz.bubble_wb   = w_ctrl.bubble_wb;
  assign hz.mem_wait    = (r_state == ST_WAIT);
  assign hz.mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl.
//   A 32-bit-counter instance is the main DUT. A second instance with 3-bit
//   counters sees the same stimulus and exercises saturation.
//   Inputs change on the falling edge. Outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int unsigned TO     = 4;
  localparam int          SAT_MX = 7;  // all-ones of the 3-bit instance

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) h_if ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  s_if ();

  assign s_if.rs1_id       = h_if.rs1_id;
  assign s_if.rs2_id       = h_if.rs2_id;
  assign s_if.rs1_used_id  = h_if.rs1_used_id;
  assign s_if.rs2_used_id  = h_if.rs2_used_id;
  assign s_if.jal_id       = h_if.jal_id;
  assign s_if.rd_ex        = h_if.rd_ex;
  assign s_if.mem_read_ex  = h_if.mem_read_ex;
  assign s_if.redirect_ex  = h_if.redirect_ex;
  assign s_if.dmem_req_mem = h_if.dmem_req_mem;
  assign s_if.dmem_ack     = h_if.dmem_ack;

  pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (h_if.slave)
  );

  pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(3)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       jal;
    logic [4:0] rd;
    logic       mrd;
    logic       redir;
    logic       req;
    logic       ack;
    logic [3:0] es;  // {stall_if, stall_id, stall_ex, stall_mem}
    logic [3:0] eb;  // {bubble_id, bubble_ex, bubble_mem, bubble_wb}
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [3:0] stalls();
    return {h_if.stall_if, h_if.stall_id, h_if.stall_ex, h_if.stall_mem};
  endfunction

  function automatic logic [3:0] bubbles();
    return {h_if.bubble_id, h_if.bubble_ex, h_if.bubble_mem, h_if.bubble_wb};
  endfunction

  function automatic int sat(input int x);
    return (x > SAT_MX) ? SAT_MX : x;
  endfunction

  function automatic vec_t mk(
    input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
    input logic jal, input logic [4:0] rd, input logic mrd, input logic redir,
    input logic req, input logic ack, input logic [3:0] es, input logic [3:0] eb);
    vec_t v;
    v = {rs1, rs2, u1, u2, jal, rd, mrd, redir, req, ack, es, eb};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    h_if.rs1_id       = v.rs1;
    h_if.rs2_id       = v.rs2;
    h_if.rs1_used_id  = v.u1;
    h_if.rs2_used_id  = v.u2;
    h_if.jal_id       = v.jal;
    h_if.rd_ex        = v.rd;
    h_if.mem_read_ex  = v.mrd;
    h_if.redirect_ex  = v.redir;
    h_if.dmem_req_mem = v.req;
    h_if.dmem_ack     = v.ack;
  endtask

  // One clock cycle: apply inputs, check controls/state/counters, then
  // advance the counter model from the expected controls of this cycle.
  task automatic cyc(input string nm, input vec_t v, input logic emw);
    @(negedge clk);
    drive(v);
    #1;
    check({nm, ".stall"},  32'(stalls()),        32'(v.es));
    check({nm, ".bubble"}, 32'(bubbles()),       32'(v.eb));
    check({nm, ".wait"},   32'(h_if.mem_wait),   32'(emw));
    check({nm, ".scnt"},   h_if.stall_cnt,       32'(exp_stall));
    check({nm, ".fcnt"},   h_if.flush_cnt,       32'(exp_flush));
    check({nm, ".sat_s"},  32'(s_if.stall_cnt),  32'(sat(exp_stall)));
    check({nm, ".sat_f"},  32'(s_if.flush_cnt),  32'(sat(exp_flush)));
    if (v.es[3]) exp_stall++;
    if (v.eb[3]) exp_flush++;
  endtask

  vec_t idle_v, hold_v, ack_v;

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    hold_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 4'h1);
    ack_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'h0, 4'h0);

    //            rs1 rs2 u1 u2 jal rd mrd rdr req ack  stall  bubble
    vecs[0]  = mk(0,  0,  0, 0, 0,  0, 0,  0,  0,  0,  4'h0,  4'h0);
    vecs[1]  = mk(3,  5,  1, 1, 0,  5, 1,  0,  0,  0,  4'hC,  4'h4);  // load-use on rs2
    vecs[2]  = mk(3,  5,  1, 0, 0,  5, 1,  0,  0,  0,  4'h0,  4'h0);  // rs2 not read
    vecs[3]  = mk(7,  2,  1, 1, 0,  7, 1,  0,  0,  0,  4'hC,  4'h4);  // load-use on rs1
    vecs[4]  = mk(0,  0,  1, 1, 0,  0, 1,  0,  0,  0,  4'h0,  4'h0);  // rd_ex = x0
    vecs[5]  = mk(3,  5,  1, 1, 0,  5, 0,  0,  0,  0,  4'h0,  4'h0);  // not a load
    vecs[6]  = mk(3,  5,  1, 1, 1,  5, 1,  1,  0,  0,  4'h0,  4'hC);  // redirect > lu, jal
    vecs[7]  = mk(0,  0,  0, 0, 1,  0, 0,  0,  0,  0,  4'h0,  4'h8);  // jal only
    vecs[8]  = mk(9,  1,  1, 0, 1,  9, 1,  0,  0,  0,  4'hC,  4'h4);  // load-use > jal
    vecs[9]  = mk(0,  0,  0, 0, 0,  0, 0,  0,  1,  1,  4'h0,  4'h0);  // same-cycle ack
    vecs[10] = mk(0,  0,  0, 0, 0,  0, 0,  1,  1,  1,  4'h0,  4'hC);  // ack + redirect
    vecs[11] = mk(0,  0,  0, 0, 0,  0, 0,  1,  0,  0,  4'h0,  4'hC);  // redirect only

    // --- reset: outputs forced to flush regardless of inputs --------------
    rst_n = 1'b0;
    drive(idle_v);
    #1;
    check("rst.stall",  32'(stalls()),         32'h0);
    check("rst.bubble", 32'(bubbles()),        32'hF);
    check("rst.wait",   32'(h_if.mem_wait),    32'h0);
    check("rst.tmo",    32'(h_if.mem_timeout), 32'h0);
    check("rst.scnt",   h_if.stall_cnt,        32'h0);
    check("rst.fcnt",   h_if.flush_cnt,        32'h0);
    @(negedge clk);
    h_if.redirect_ex = 1'b1;
    h_if.jal_id      = 1'b1;
    #1;
    check("rst.force_stall",  32'(stalls()),  32'h0);
    check("rst.force_bubble", 32'(bubbles()), 32'hF);
    drive(idle_v);
    #1 rst_n = 1'b1;

    // --- single-cycle rule table ------------------------------------------
    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // --- dmem wait: 3 held cycles, then ack --------------------------------
    for (int c = 0; c < 3; c++) cyc($sformatf("wait%0d", c), hold_v, c > 0);
    cyc("wait.ack", ack_v, 1'b1);
    cyc("wait.after", idle_v, 1'b0);

    // --- hold masks redirect; flush lands on the ack cycle ------------------
    for (int c = 0; c < 2; c++)
      cyc($sformatf("mask%0d", c), mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'hF, 4'h1), c > 0);
    cyc("mask.ack", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4'h0, 4'hC), 1'b1);
    cyc("mask.after", idle_v, 1'b0);

    // --- watchdog: ack withheld 6 cycles -----------------------------------
    for (int c = 0; c < 6; c++) begin
      cyc($sformatf("to%0d", c), hold_v, c > 0);
      check($sformatf("to%0d.flag", c), 32'(h_if.mem_timeout), 32'(c >= 4));
    end
    cyc("to.ack", ack_v, 1'b1);
    check("to.ack.flag", 32'(h_if.mem_timeout), 32'h1);
    cyc("to.after", idle_v, 1'b0);
    check("to.sticky", 32'(h_if.mem_timeout), 32'h1);

    // --- async reset in the middle of WAIT ---------------------------------
    cyc("rw.enter", hold_v, 1'b0);
    @(negedge clk);
    #1;
    check("rw.in_wait", 32'(h_if.mem_wait), 32'h1);
    #2;
    rst_n = 1'b0;
    h_if.redirect_ex = 1'b1;
    #1;
    check("rw.stall",   32'(stalls()),          32'h0);
    check("rw.bubble",  32'(bubbles()),         32'hF);
    check("rw.wait",    32'(h_if.mem_wait),     32'h0);
    check("rw.tmo",     32'(h_if.mem_timeout),  32'h0);
    check("rw.scnt",    h_if.stall_cnt,         32'h0);
    check("rw.fcnt",    h_if.flush_cnt,         32'h0);
    check("rw.sat_s",   32'(s_if.stall_cnt),    32'h0);
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    drive(idle_v);
    #1 rst_n = 1'b1;
    cyc("post.idle", idle_v, 1'b0);
    cyc("post.lu", mk(0, 6, 0, 1, 0, 6, 1, 0, 0, 0, 4'hC, 4'h4), 1'b0);
    cyc("post.end", idle_v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/bubble controller for the five-stage pipeline. It drives the stall_*/bubble_* pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the PC register.
- It resolves four hazard types:
  - load-use hazards
  - taken-branch/jalr redirects from EX
  - jal redirects from ID
  - variable-latency data-memory waits, handled through a req/ack handshake
- It also keeps a wait-timeout watchdog and saturating stall/flush performance counters.

Parameters:
- TIMEOUT_CYC, 255: number of consecutive dmem wait cycles before mem_timeout is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rs1_id, rs2_id  in  5 each  source registers of the instruction in ID
- rs1_used_id, rs2_used_id  in  1 each  the ID instruction actually reads rs1 / rs2
- jal_id  in  1  jal decoded in ID; fetch is redirected this cycle
- rd_ex  in  5  destination register of the instruction in EX
- mem_read_ex  in  1  the EX instruction is a load
- redirect_ex  in  1  taken branch or jalr resolved in EX
- dmem_req_mem  in  1  the MEM stage issues a data-memory access
- dmem_ack  in  1  data memory completes the access this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register
- bubble_id, bubble_ex, bubble_mem, bubble_wb  out  1 each  load default_val (NOP) into the IF-ID / ID-EX / EX-MEM / MEM-WB register
- mem_wait  out  1  the FSM is in WAIT
- mem_timeout  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  saturating count of cycles with stall_if=1
- flush_cnt  out  CNT_W  saturating count of redirect events

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to RUN; counters and mem_timeout clear to 0.
  - Outputs are forced to all stall_*=0 and all bubble_*=1, which flushes the pipe.
  - The stall and bubble outputs are combinational from registered state plus inputs. The first cycle after rst_n rises uses normal rules.
- FSM states: RUN, WAIT.
  - RUN -> WAIT when dmem_req_mem=1 and dmem_ack=0.
  - WAIT -> RUN when dmem_ack=1.
  - An ack in the same cycle as the request stays in RUN with no stall.
- Internal signals:
  - mem_hold = dmem_req_mem & ~dmem_ack.
  - load_use = mem_read_ex & (rd_ex != 0) & ((rs1_used_id & rs1_id == rd_ex) | (rs2_used_id & rs2_id == rd_ex)).
- Priority, highest first (exactly one rule applies per cycle; all unlisted outputs are 0):
  1. mem_hold: stall_if = stall_id = stall_ex = stall_mem = 1, bubble_wb = 1. Redirect, load-use and jal inputs are ignored this cycle; they re-evaluate once the hold releases because the frozen EX/ID keep their contents.
  2. redirect_ex: bubble_id = bubble_ex = 1. This kills the two younger instructions, including any jal in ID and any load-use stall.
  3. load_use: stall_if = stall_id = 1, bubble_ex = 1. This gives a one-cycle bubble; MEM-to-EX forwarding covers the rest.
  4. jal_id: bubble_id = 1.
- Watchdog:
  - wait_cnt increments on each cycle with mem_hold=1 and clears when mem_hold=0.
  - When wait_cnt reaches TIMEOUT_CYC, mem_timeout sets and stays set until reset.
  - wait_cnt saturates; it does not wrap.
  - The pipeline keeps stalling after a timeout; recovery is the trap handler's job.
- Counters:
  - stall_cnt adds 1 on any cycle with stall_if=1.
  - flush_cnt adds 1 on any cycle where rule 2 or rule 4 is the rule that applies.
  - Both counters saturate at all-ones.
- rd_ex = 0 never produces a load-use stall. Stall-without-bubble on the same register never occurs.

Decomposition:
- Shared defines file holds the FSM state encoding (ST_RUN, ST_WAIT) and the hazard-priority constants, so the tracer can decode them.
- The saturating counter is a natural sub-module, sat_counter (params WIDTH; inputs inc, clear). It is instantiated for stall_cnt, flush_cnt and wait_cnt.

Test Plan:
- Load-use: lw x5 in EX (mem_read_ex=1, rd_ex=5), ID add with rs2_id=5, rs2_used_id=1 -> exactly one cycle of stall_if=stall_id=bubble_ex=1; stall_cnt=1. Repeat with rs2_used_id=0 -> no stall.
- Redirect collides with load-use and jal: redirect_ex=1, load_use true, jal_id=1 in the same cycle -> bubble_id=bubble_ex=1, stall_if=0, flush_cnt increments by 1.
- Memory wait: dmem_req_mem=1, dmem_ack=0 for 3 cycles then ack -> 3 cycles of stalls 1-4 with bubble_wb=1 and mem_wait=1, RUN on the ack cycle. The same-cycle ack case produces no stall.
- Hold masks redirect: redirect_ex=1 during a dmem wait -> no bubble_id/bubble_ex until the ack cycle; the flush happens on the ack cycle.
- Timeout: TIMEOUT_CYC=4, ack withheld 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after the ack.
- Async reset mid-WAIT: drop rst_n between clock edges -> immediately all bubble_*=1, stalls 0, mem_wait=0, counters 0.
